// File: rtl/safe_bus_mux.sv
// Hart-to-bus OBI mux with INDEP/DMR/TMR lockstep modes, drain-before-switch mode control
// and registered mismatch flags. Define SAFE_BUS_MUX_ERR_CNT_EN to build the mismatch error counter.
package safe_bus_mux_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic [1:0] {
    MODE_INDEP = 2'b00,
    MODE_DMR   = 2'b01,
    MODE_TMR   = 2'b10,
    MODE_ILL   = 2'b11
  } mode_e;
endpackage

// state  | meaning
// RUN    | normal traffic, mode requests accepted
// DRAIN  | new requests blocked, waiting for every outstanding response
// SWITCH | load the pending mode and acknowledge
module safe_bus_mux
  import safe_bus_mux_pkg::*;
#(
  parameter int NHARTS    = 3,
  parameter int MAX_OUTST = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  obi_req_t  [NHARTS-1:0]   core_req_i,
  output obi_resp_t [NHARTS-1:0]   core_resp_o,
  output obi_req_t  [NHARTS-1:0]   bus_req_o,
  input  obi_resp_t [NHARTS-1:0]   bus_resp_i,
  input  logic [1:0]               mode_req_i,
  input  logic                     mode_req_valid_i,
  output logic                     mode_ack_o,
  output logic                     mode_err_o,
  output logic [1:0]               mode_o,
  output logic                     mismatch_o,
  output logic [NHARTS-1:0]        mismatch_mask_o,
  output logic [ERR_CNT_W-1:0]     err_count_o,
  input  logic                     err_clear_i
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_SWITCH = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             mis_q, mis_d;
  logic [NHARTS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q [NHARTS];
  logic [CNT_W-1:0] cnt_d [NHARTS];

  logic [NHARTS-1:0] part;
  logic [NHARTS-1:0] blocked;
  logic [NHARTS-1:0] diff;
  logic [NHARTS-1:0] inc;
  logic [NHARTS-1:0] dec;
  logic              any_req;
  logic              all_idle;
  logic              mode_illegal;
  obi_req_t          maj_req;
  obi_req_t          lock_req;

  if (NHARTS >= 3) begin : g_maj
    assign maj_req = (core_req_i[0] & core_req_i[1]) |
                     (core_req_i[0] & core_req_i[2]) |
                     (core_req_i[1] & core_req_i[2]);
  end else begin : g_no_maj
    assign maj_req = core_req_i[0];
  end

  assign lock_req = (mode_q == MODE_TMR) ? maj_req : core_req_i[0];

  always_comb begin
    part    = '0;
    blocked = '0;
    for (int i = 0; i < NHARTS; i++) begin
      part[i]    = ((mode_q == MODE_DMR) && (i < 2)) || ((mode_q == MODE_TMR) && (i < 3));
      blocked[i] = (state_q != ST_RUN) || (cnt_q[i] == CNT_MAX);
    end
  end

  // Participating harts share port 0; the other participating bus ports stay idle.
  always_comb begin
    for (int i = 0; i < NHARTS; i++) begin
      bus_req_o[i]   = core_req_i[i];
      core_resp_o[i] = bus_resp_i[i];
      if (part[i]) begin
        bus_req_o[i]       = (i == 0) ? lock_req : '0;
        core_resp_o[i]     = bus_resp_i[0];
        core_resp_o[i].gnt = bus_resp_i[0].gnt & ~blocked[0];
      end else begin
        core_resp_o[i].gnt = bus_resp_i[i].gnt & ~blocked[i];
      end
      bus_req_o[i].req = bus_req_o[i].req & ~blocked[i];
    end
  end

  always_comb begin
    inc      = '0;
    dec      = '0;
    all_idle = 1'b1;
    for (int i = 0; i < NHARTS; i++) begin
      inc[i]   = bus_req_o[i].req & bus_resp_i[i].gnt;
      dec[i]   = bus_resp_i[i].rvalid && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec[i] && !inc[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (cnt_q[i] != '0) begin
        all_idle = 1'b0;
      end
    end
  end

  always_comb begin
    any_req = 1'b0;
    diff    = '0;
    for (int i = 0; i < NHARTS; i++) begin
      if (part[i]) begin
        any_req = any_req | core_req_i[i].req;
        diff[i] = (core_req_i[i] != lock_req);
      end
    end
    mis_d  = any_req && (|diff);
    mask_d = '0;
    if (mis_d) begin
      mask_d = (mode_q == MODE_TMR) ? diff : NHARTS'(2'b11);
    end
  end

  assign mode_illegal = (mode_req_i == MODE_ILL) || ((mode_req_i == MODE_TMR) && (NHARTS < 3));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_req_valid_i) begin
          if (mode_illegal) begin
            err_d = 1'b1;
          end else if (mode_req_i == mode_q) begin
            ack_d = 1'b1;
          end else begin
            pend_d  = mode_req_i;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (all_idle) begin
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        mode_d  = pend_q;
        ack_d   = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      mode_q  <= MODE_INDEP;
      pend_q  <= MODE_INDEP;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      mask_q  <= '0;
      for (int i = 0; i < NHARTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      mask_q  <= mask_d;
      for (int i = 0; i < NHARTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef SAFE_BUS_MUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] errc_q, errc_d;

  // Clear wins over a same-cycle mismatch; the count saturates at all-ones.
  always_comb begin
    errc_d = errc_q;
    if (err_clear_i) begin
      errc_d = '0;
    end else if (mis_d && (errc_q != '1)) begin
      errc_d = errc_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      errc_q <= '0;
    end else begin
      errc_q <= errc_d;
    end
  end

  assign err_count_o = errc_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear_i;
  assign err_count_o      = '0;
`endif

  assign mode_o          = mode_q;
  assign mode_ack_o      = ack_q;
  assign mode_err_o      = err_q;
  assign mismatch_o      = mis_q;
  assign mismatch_mask_o = mask_q;

endmodule

// File: tb/tb_safe_bus_mux.sv
// Bench for safe_bus_mux: directed scenarios plus random traffic, all checked against a
// cycle-level reference model of the mode, lockstep and outstanding-request rules.
module tb_safe_bus_mux;
  import safe_bus_mux_pkg::*;

  localparam int NH   = 3;
  localparam int MAXO = 4;
  localparam int EW   = 8;
`ifdef SAFE_BUS_MUX_ERR_CNT_EN
  localparam bit ERRC_EN = 1'b1;
`else
  localparam bit ERRC_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  obi_req_t  [NH-1:0] core_req, bus_req;
  obi_resp_t [NH-1:0] core_resp, bus_resp;
  logic [1:0]         mode_req, mode;
  logic               mode_val, ack, merr, mis, eclr;
  logic [NH-1:0]      mask;
  logic [EW-1:0]      errc;

  obi_req_t  [1:0] core_req2, bus_req2;
  obi_resp_t [1:0] core_resp2, bus_resp2;
  logic [1:0]      mode_req2, mode2, mask2;
  logic            mode_val2, ack2, merr2, mis2;
  logic [EW-1:0]   errc2;

  safe_bus_mux #(.NHARTS(NH), .MAX_OUTST(MAXO), .ERR_CNT_W(EW)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req), .core_resp_o(core_resp),
    .bus_req_o(bus_req), .bus_resp_i(bus_resp),
    .mode_req_i(mode_req), .mode_req_valid_i(mode_val),
    .mode_ack_o(ack), .mode_err_o(merr), .mode_o(mode),
    .mismatch_o(mis), .mismatch_mask_o(mask),
    .err_count_o(errc), .err_clear_i(eclr)
  );

  safe_bus_mux #(.NHARTS(2), .MAX_OUTST(MAXO), .ERR_CNT_W(EW)) u_dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req2), .core_resp_o(core_resp2),
    .bus_req_o(bus_req2), .bus_resp_i(bus_resp2),
    .mode_req_i(mode_req2), .mode_req_valid_i(mode_val2),
    .mode_ack_o(ack2), .mode_err_o(merr2), .mode_o(mode2),
    .mismatch_o(mis2), .mismatch_mask_o(mask2),
    .err_count_o(errc2), .err_clear_i(1'b0)
  );

  // Reference model state: mode, phase (0 run, 1 drain, 2 switch), outstanding counts.
  int            md, phase, pend;
  int            outst [NH];
  bit            m_ack, m_merr, m_mis;
  logic [NH-1:0] m_mask;
  int            m_errc;
  int            checks, failures;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nparts();
    return (md == 1) ? 2 : (md == 2) ? 3 : 0;
  endfunction

  function automatic bit blocked(int i);
    return (phase != 0) || (outst[i] == MAXO);
  endfunction

  function automatic obi_req_t lock_of();
    logic [$bits(obi_req_t)-1:0] a, b, c, r;
    if (md != 2) return core_req[0];
    a = core_req[0]; b = core_req[1]; c = core_req[2];
    for (int k = 0; k < $bits(obi_req_t); k++)
      r[k] = ((int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2);
    return r;
  endfunction

  function automatic obi_req_t exp_bus(int i);
    obi_req_t r;
    r = core_req[i];
    if (i < nparts()) r = (i == 0) ? lock_of() : '0;
    if (blocked(i)) r.req = 1'b0;
    return r;
  endfunction

  function automatic obi_resp_t exp_resp(int i);
    int src;
    obi_resp_t r;
    src   = (i < nparts()) ? 0 : i;
    r     = bus_resp[src];
    r.gnt = bus_resp[src].gnt & !blocked(src);
    return r;
  endfunction

  task automatic model_reset();
    md = 0; phase = 0; pend = 0;
    for (int i = 0; i < NH; i++) outst[i] = 0;
    m_ack = 0; m_merr = 0; m_mis = 0; m_mask = '0; m_errc = 0;
  endtask

  task automatic model_step();
    int np;
    obi_req_t lk, eb;
    bit anyreq, nmis, all0;
    bit issued [NH];
    logic [NH-1:0] diff, nmask;
    np = nparts(); lk = lock_of();
    anyreq = 0; diff = '0; all0 = 1;
    for (int i = 0; i < NH; i++) begin
      eb = exp_bus(i);
      issued[i] = eb.req && bus_resp[i].gnt;
      if (outst[i] != 0) all0 = 0;
      if (i < np) begin
        anyreq = anyreq | core_req[i].req;
        diff[i] = (core_req[i] != lk);
      end
    end
    nmis  = anyreq && (diff != '0);
    nmask = !nmis ? '0 : (md == 2) ? diff : 3'b011;
    if (!ERRC_EN || eclr) m_errc = 0;
    else if (nmis && m_errc < (2**EW - 1)) m_errc++;
    m_mis = nmis; m_mask = nmask;
    m_ack = 0; m_merr = 0;
    case (phase)
      0: if (mode_val) begin
        if (mode_req == 2'd3 || (mode_req == 2'd2 && NH < 3)) m_merr = 1;
        else if (int'(mode_req) == md) m_ack = 1;
        else begin pend = int'(mode_req); phase = 1; end
      end
      1: if (all0) phase = 2;
      default: begin md = pend; m_ack = 1; phase = 0; end
    endcase
    for (int i = 0; i < NH; i++) begin
      int old;
      old = outst[i];
      outst[i] = old + int'(issued[i]) - int'(bus_resp[i].rvalid && old > 0);
    end
  endtask

  task automatic settle();
    #3;
    for (int i = 0; i < NH; i++) begin
      check_eq($sformatf("bus_req[%0d]", i), bus_req[i], exp_bus(i));
      check_eq($sformatf("core_resp[%0d]", i), core_resp[i], exp_resp(i));
    end
    check_eq("mode_o", mode, md);
    check_eq("mode_ack", ack, m_ack);
    check_eq("mode_err", merr, m_merr);
    check_eq("mismatch", mis, m_mis);
    check_eq("mismatch_mask", mask, m_mask);
    check_eq("err_count", errc, m_errc);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    core_req = '0; bus_resp = '0;
    mode_req = 2'd0; mode_val = 1'b0; eclr = 1'b0;
    mode_req2 = 2'd0; mode_val2 = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq("rst_mode", mode, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_err", merr, 0);
    check_eq("rst_mismatch", mis, 0);
    check_eq("rst_mask", mask, 0);
    check_eq("rst_errc", errc, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic wait_ack(input int m, input string tag);
    bit done;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      for (int i = 0; i < NH; i++) bus_resp[i].rvalid = (outst[i] > 0);
      settle();
      if (ack) done = 1;
      advance();
    end
    idle();
    check_eq({tag, "_ack_seen"}, done, 1);
    check_eq({tag, "_mode"}, mode, m);
  endtask

  task automatic change_mode(input int m);
    idle();
    mode_req = 2'(m); mode_val = 1'b1;
    settle(); advance();
    mode_val = 1'b0;
    wait_ack(m, "chg");
  endtask

  task automatic rand_cycle();
    int np, k;
    np = nparts();
    for (int i = 0; i < NH; i++) begin
      core_req[i].req   = ($urandom_range(0, 9) < 6);
      core_req[i].we    = 1'($urandom_range(0, 1));
      core_req[i].be    = 4'($urandom_range(0, 15));
      core_req[i].addr  = 32'($urandom_range(0, 15)) << 2;
      core_req[i].wdata = $urandom;
      bus_resp[i].gnt    = ($urandom_range(0, 9) < 7);
      bus_resp[i].rvalid = (outst[i] > 0) && ($urandom_range(0, 1) == 1);
      bus_resp[i].rdata  = $urandom;
    end
    if (np > 0) begin
      for (int i = 1; i < np; i++) core_req[i] = core_req[0];
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, np - 1);
        core_req[k].addr = core_req[k].addr ^ 32'h4;
      end
    end
    mode_val = ($urandom_range(0, 29) == 0);
    mode_req = 2'($urandom_range(0, 3));
    eclr     = ($urandom_range(0, 49) == 0);
    settle();
    advance();
  endtask

  initial begin
    checks = 0; failures = 0;
    core_req2 = '0; bus_resp2 = '0;
    do_reset();

    // INDEP: independent addresses and per-hart response routing
    for (int i = 0; i < NH; i++) begin
      core_req[i].req  = 1'b1;
      core_req[i].addr = 32'h100 * (i + 1);
      bus_resp[i].gnt  = 1'b1;
    end
    settle();
    for (int i = 0; i < NH; i++) check_eq($sformatf("indep_addr[%0d]", i), bus_req[i].addr, 32'h100 * (i + 1));
    advance();
    idle();
    bus_resp[1].rvalid = 1'b1; bus_resp[1].rdata = 32'hBEEF0001;
    settle();
    check_eq("indep_rv0", core_resp[0].rvalid, 0);
    check_eq("indep_rv1", core_resp[1].rvalid, 1);
    check_eq("indep_rv2", core_resp[2].rvalid, 0);
    advance();
    idle();
    bus_resp[0].rvalid = 1'b1; bus_resp[0].rdata = 32'hA0;
    bus_resp[2].rvalid = 1'b1; bus_resp[2].rdata = 32'hC2;
    settle();
    check_eq("indep_rdata0", core_resp[0].rdata, 32'hA0);
    check_eq("indep_rdata2", core_resp[2].rdata, 32'hC2);
    check_eq("indep_rv1_off", core_resp[1].rvalid, 0);
    advance();

    // Drain two outstanding reads on port 0 before switching to TMR
    do_reset();
    core_req[0].req = 1'b1; core_req[0].addr = 32'h80; bus_resp[0].gnt = 1'b1;
    settle(); advance();
    settle(); advance();
    core_req[0].req = 1'b0; mode_req = 2'd2; mode_val = 1'b1;
    settle(); advance();
    mode_val = 1'b0;
    for (int i = 0; i < NH; i++) begin
      core_req[i].req = 1'b1; bus_resp[i].gnt = 1'b1;
    end
    for (int n = 0; n < 5; n++) begin
      bus_resp[0].rvalid = (n >= 3);
      settle();
      for (int i = 0; i < NH; i++) check_eq($sformatf("drain_gnt[%0d]", i), core_resp[i].gnt, 0);
      check_eq("drain_bus_req0", bus_req[0].req, 0);
      advance();
    end
    idle();
    wait_ack(2, "drain_switch");

    // TMR: hart 1 dissents on the address
    for (int i = 0; i < NH; i++) begin
      core_req[i].req = 1'b1; core_req[i].we = 1'b1; core_req[i].be = 4'hF;
      core_req[i].addr = 32'h40; core_req[i].wdata = 32'h1234;
    end
    core_req[1].addr = 32'h44;
    bus_resp[0].gnt = 1'b1;
    settle();
    check_eq("tmr_bus_addr", bus_req[0].addr, 32'h40);
    check_eq("tmr_bus1_tied", bus_req[1], 0);
    advance();
    idle();
    settle();
    check_eq("tmr_mismatch", mis, 1);
    check_eq("tmr_mask", mask, 3'b010);
    check_eq("tmr_errc", errc, ERRC_EN ? 1 : 0);
    advance();

    // DMR: hart 1 wdata differs, then a mismatch with a simultaneous clear
    change_mode(1);
    for (int i = 0; i < 2; i++) begin
      core_req[i].req = 1'b1; core_req[i].we = 1'b1; core_req[i].addr = 32'h10;
    end
    core_req[0].wdata = 32'hAAAA5555; core_req[1].wdata = 32'h0000FFFF;
    settle();
    check_eq("dmr_bus_wdata", bus_req[0].wdata, 32'hAAAA5555);
    advance();
    eclr = 1'b1;
    settle();
    check_eq("dmr_mismatch", mis, 1);
    check_eq("dmr_mask", mask, 3'b011);
    check_eq("dmr_errc", errc, ERRC_EN ? 2 : 0);
    advance();
    idle();
    settle();
    check_eq("dmr_clear_prio", errc, 0);
    advance();

    // Outstanding limit on port 2 (pass-through while in DMR)
    core_req[2].req = 1'b1; core_req[2].addr = 32'h300; bus_resp[2].gnt = 1'b1;
    for (int n = 0; n < MAXO; n++) begin
      settle();
      check_eq($sformatf("lim_gnt_%0d", n), core_resp[2].gnt, 1);
      advance();
    end
    settle();
    check_eq("lim_full_gnt", core_resp[2].gnt, 0);
    check_eq("lim_full_req", bus_req[2].req, 0);
    advance();
    bus_resp[2].rvalid = 1'b1;
    settle(); advance();
    bus_resp[2].rvalid = 1'b0;
    settle();
    check_eq("lim_regrant", core_resp[2].gnt, 1);
    advance();

    // Illegal requests: mode 11 here, TMR on the two-hart instance
    idle();
    mode_req = 2'd3; mode_val = 1'b1;
    mode_req2 = 2'd2; mode_val2 = 1'b1;
    settle(); advance();
    idle();
    settle();
    check_eq("ill11_err", merr, 1);
    check_eq("ill11_mode", mode, 1);
    check_eq("nh2_tmr_err", merr2, 1);
    check_eq("nh2_tmr_mode", mode2, 0);
    advance();
    settle();
    check_eq("nh2_err_pulse", merr2, 0);
    advance();

    // Reset while draining (port 2 still has outstanding requests)
    mode_req = 2'd0; mode_val = 1'b1;
    settle(); advance();
    mode_val = 1'b0;
    core_req[2].req = 1'b1; bus_resp[2].gnt = 1'b1;
    settle();
    check_eq("rstdrain_gated", core_resp[2].gnt, 0);
    advance();
    do_reset();
    core_req[0].req = 1'b1; bus_resp[0].gnt = 1'b1;
    core_req[2].req = 1'b1; bus_resp[2].gnt = 1'b1;
    settle();
    check_eq("rstdrain_cnt0", core_resp[0].gnt, 1);
    check_eq("rstdrain_cnt2", core_resp[2].gnt, 1);
    advance();

    for (int n = 0; n < 2500; n++) rand_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
